// File: rtl/mul32_seq.sv
// Multi-cycle 32x32->64 multiplier built from four passes through one 18x18 signed multiplier.
// Optional macro MUL32_ZERO_SKIP_EN: zero operands bypass the multiplier and complete next cycle.

module mult18x18_1c (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [17:0] x,
    input  logic [17:0] y,
    output logic [35:0] p
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else if (en) begin
            p <= $signed(x) * $signed(y);
        end
    end
endmodule

module mul32_seq #(
    parameter int MULT_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        a_signed,
    input  logic        b_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state;
    logic [31:0]   a_q, b_q;
    logic          as_q, bs_q;
    logic [1:0]    idx;
    logic [63:0]   acc;
    // Tags travel alongside the multiplier pipeline so each product meets its shift amount.
    logic [MULT_LAT-1:0] tag_v;
    logic [1:0]          tag_k [MULT_LAT];

    logic [17:0] al, ah, bl, bh, mx, my;
    logic [35:0] prod;
    logic [63:0] sext, term, acc_sum;
    logic        mult_rst;
    logic        tag_hit, tag_last;

    assign mult_rst = ~rst_n;

    mult18x18_1c u_mult (
        .clk (clk),
        .rst (mult_rst),
        .en  (1'b1),
        .x   (mx),
        .y   (my),
        .p   (prod)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        al = {2'b00, a_q[15:0]};
        ah = {{2{a_q[31] & as_q}}, a_q[31:16]};
        bl = {2'b00, b_q[15:0]};
        bh = {{2{b_q[31] & bs_q}}, b_q[31:16]};
        mx = al;
        my = bl;
        case (idx)
            2'd0: begin mx = al; my = bl; end
            2'd1: begin mx = al; my = bh; end
            2'd2: begin mx = ah; my = bl; end
            2'd3: begin mx = ah; my = bh; end
            default: ;
        endcase
    end

    always_comb begin
        sext = {{28{prod[35]}}, prod};
        term = sext;
        case (tag_k[MULT_LAT-1])
            2'd0:       term = sext;
            2'd1, 2'd2: term = sext << 16;
            2'd3:       term = sext << 32;
            default: ;
        endcase
        acc_sum  = acc + term;
        tag_hit  = tag_v[MULT_LAT-1];
        tag_last = tag_hit && (tag_k[MULT_LAT-1] == 2'd3);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            acc       <= '0;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            as_q      <= 1'b0;
            bs_q      <= 1'b0;
            tag_v     <= '0;
            for (int i = 0; i < MULT_LAT; i++) tag_k[i] <= '0;
        end else begin
            tag_v[0] <= (state == ISSUE);
            tag_k[0] <= idx;
            for (int i = 1; i < MULT_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_k[i] <= tag_k[i-1];
            end
            if (tag_hit) acc <= acc_sum;

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        as_q     <= a_signed;
                        bs_q     <= b_signed;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
`ifdef MUL32_ZERO_SKIP_EN
                        if (a == '0 || b == '0) begin
                            result    <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
`else
                        state <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) state <= DRAIN;
                end
                DRAIN: begin
                    if (tag_last) begin
                        result    <= acc_sum;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: directed vector table, handshake corner sequences,
// and randomized operations against an arithmetic reference model.

module tb_mul32_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        a_signed, b_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int checks   = 0;
    int failures = 0;

    mul32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        as;
        logic        bs;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Full product of the operands interpreted per their sign flags, reduced mod 2^64.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic xs, input logic ys);
        logic [63:0] ex, ey;
        ex = xs ? {{32{x[31]}}, x} : {32'h0, x};
        ey = ys ? {{32{y[31]}}, y} : {32'h0, y};
        return ex * ey;
    endfunction

    function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef MUL32_ZERO_SKIP_EN
        return (x == 0 || y == 0) ? 1 : 6;
`else
        return 6;
`endif
    endfunction

    // Called at a falling edge; returns at the falling edge of cycle T+1 after the accept edge T.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic xs, input logic ys);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
        a = x; b = y; a_signed = xs; b_signed = ys;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        a_signed = 1'($urandom); b_signed = 1'($urandom);
    endtask

    // lat counts cycles after the accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_ovalid_cleared"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_vec(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic xs, input logic ys, input logic [63:0] exp);
        int lat;
        start_op(x, y, xs, ys);
        wait_done(lat);
        check({name, "_result"}, result, exp);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat(x, y)));
        finish_op(name);
    endtask

    vec_t vecs[$];

    initial begin
        int          lat;
        logic [31:0] x, y, px, py;
        logic        xs, ys;
        logic [63:0] exp;

        vecs.push_back('{"unsigned_basic", 32'h0001_0003, 32'h0002_0005, 1'b0, 1'b0, 64'h0000_0002_000B_000F});
        vecs.push_back('{"neg2_times_7_ss", 32'hFFFF_FFFE, 32'h0000_0007, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2});
        vecs.push_back('{"neg2_times_7_us", 32'hFFFF_FFFE, 32'h0000_0007, 1'b0, 1'b1, 64'h0000_0006_FFFF_FFF2});
        vecs.push_back('{"min_sq_ss", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000});
        vecs.push_back('{"ones_uu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{"ones_ss", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001});
        vecs.push_back('{"ones_su", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001});
        vecs.push_back('{"ones_us", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0001});
        vecs.push_back('{"zero_a", 32'h0000_0000, 32'h0000_1234, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{"three_by_five", 32'd3, 32'd5, 1'b0, 1'b0, 64'd15});

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", result, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, vecs[i].exp);

        // Backpressure with a new operation pending upstream.
        x = 32'h1234_5678; y = 32'h9ABC_DEF0; xs = 1'b1; ys = 1'b0;
        exp = model(x, y, xs, ys);
        start_op(x, y, xs, ys);
        wait_done(lat);
        check("bp_latency", 64'(lat), 64'd6);
        px = 32'h0000_7001; py = 32'hFFFF_0003;
        a = px; b = py; a_signed = 1'b0; b_signed = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid_held", 64'(out_valid), 64'd1);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_result_stable", result, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_pending_accepted", 64'(in_ready), 64'd0);
        a = $urandom; b = $urandom;
        wait_done(lat);
        check("bp_pending_latency", 64'(lat), 64'd6);
        check("bp_pending_result", result, model(px, py, 1'b0, 1'b1));
        finish_op("bp_pending");

        // Reset asserted in cycle T+3 of an operation.
        start_op(32'hDEAD_BEEF, 32'h0000_0101, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec("after_reset_3x5", 32'd3, 32'd5, 1'b0, 1'b0, 64'd15);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            x = $urandom; y = $urandom;
            xs = 1'($urandom); ys = 1'($urandom);
            if (i % 8 == 7) x[31:16] = 16'hFFFF;
            run_vec("random", x, y, xs, ys, model(x, y, xs, ys));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
